// File: rtl/conv3x3_stream_engine.sv
// conv3x3_stream_engine: pipelined multi-kernel 3x3 convolution with double-buffered coefficients
module conv3x3_stream_engine #(
  parameter int PIX_W = 8,
  parameter int COEF_W = 4,
  parameter int CH = 2,
  parameter int OUT_W = 16,
  localparam int ACC_W = PIX_W + COEF_W + 4,
  localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [9*PIX_W-1:0]    in_window,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_ch,
  input  logic [9*COEF_W-1:0]   cfg_data,
  input  logic [1:0]            cfg_mode,
  input  logic                  cfg_commit,
  output logic                  cfg_busy
);
  localparam int P_W = PIX_W + COEF_W;
  localparam int E_W = (ACC_W + 2 > OUT_W) ? ACC_W + 2 : OUT_W;
  localparam logic signed [E_W-1:0] sat_max = {{(E_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [E_W-1:0] sat_min = {{(E_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [IDX_W:0] ch_lim = (IDX_W+1)'(CH);
  logic [9*COEF_W-1:0] shadow [CH];
  logic [9*COEF_W-1:0] active [CH];
  logic [1:0] mode;
  logic en, empty, v1, v2, v3;
  logic signed [P_W-1:0] prod_d [CH][9];
  logic signed [P_W-1:0] prod_q [CH][9];
  logic signed [ACC_W-1:0] row_d [CH][3];
  logic signed [ACC_W-1:0] row_q [CH][3];
  logic signed [ACC_W-1:0] sum_d [CH];
  logic signed [ACC_W-1:0] sum_q [CH];
  logic [CH*OUT_W-1:0] res_d;
  assign en = !out_valid || out_ready;
  assign in_ready = en && !cfg_busy && !rst;
  assign empty = !(v1 || v2 || v3 || out_valid);
  function automatic logic signed [P_W-1:0] mul(input logic [PIX_W-1:0] p, input logic [COEF_W-1:0] k);
    return $signed({{COEF_W{1'b0}}, p}) * $signed({{PIX_W{k[COEF_W-1]}}, k});
  endfunction
  function automatic logic signed [E_W-1:0] mag(input logic signed [ACC_W-1:0] s);
    return s < 0 ? -E_W'(s) : E_W'(s);
  endfunction
  // mode 3 keeps channel 0 raw and gives every other channel |ch0|+|chN|
  function automatic logic signed [E_W-1:0] post(input int c, input logic [1:0] m,
                                                 input logic signed [ACC_W-1:0] s0,
                                                 input logic signed [ACC_W-1:0] s);
    return m == 2'd0 ? E_W'(s) : m == 2'd1 ? mag(s) : m == 2'd2 ? (s < 0 ? '0 : E_W'(s)) :
           (c == 0) ? (CH == 1 ? mag(s) : E_W'(s)) : mag(s0) + mag(s);
  endfunction
  function automatic logic [OUT_W-1:0] sat(input logic signed [E_W-1:0] v);
    return v > sat_max ? sat_max[OUT_W-1:0] : v < sat_min ? sat_min[OUT_W-1:0] : v[OUT_W-1:0];
  endfunction
  always_comb begin
    res_d = '0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 9; k++)
        prod_d[c][k] = mul(in_window[(8-k)*PIX_W +: PIX_W], active[c][(8-k)*COEF_W +: COEF_W]);
      for (int r = 0; r < 3; r++)
        row_d[c][r] = ACC_W'(prod_q[c][3*r]) + ACC_W'(prod_q[c][3*r+1]) + ACC_W'(prod_q[c][3*r+2]);
      sum_d[c] = row_q[c][0] + row_q[c][1] + row_q[c][2];
      res_d[c*OUT_W +: OUT_W] = sat(post(c, mode, sum_q[0], sum_q[c]));
    end
  end
  // the copy only happens with every stage empty, so in-flight windows keep their kernels
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      cfg_busy <= 1'b0;
      mode <= 2'd0;
      shadow <= '{default: '0};
      active <= '{default: '0};
    end else begin
      if (cfg_we && {1'b0, cfg_ch} < ch_lim) shadow[cfg_ch] <= cfg_data;
      if (cfg_busy && empty) begin
        active <= shadow;
        mode <= cfg_mode;
      end
      cfg_busy <= cfg_busy ? !empty : cfg_commit;
      if (en) begin
        v1 <= in_valid && in_ready;
        v2 <= v1;
        v3 <= v2;
        out_valid <= v3;
        out_data <= res_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (en) begin
      prod_q <= prod_d;
      row_q <= row_d;
      sum_q <= sum_d;
    end
  end
endmodule
